// File: rtl/axi_aw_router_if.sv
// axi_aw_router_if
//   Bundles the write-address, write-data and default-slave response
//   signals seen by axi_aw_router.
//   Modports:
//     slave  - the router's view: takes the master AW/W channels, drives
//              the per-slave AW/W fan-out and the default-slave B channel.
//     master - the surrounding system's view (master plus slaves), the
//              mirror image of the slave modport.
//   Width macros (AXI_ID_BITS, AXI_ADDR_BITS, AXI_LEN_BITS, AXI_SIZE_BITS,
//   AXI_IDS_BITS) take defaults here unless defined beforehand. The
//   slave-side ID is four bits wider than the master ID, because the
//   4-bit master index is prepended to it.

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS (`AXI_ID_BITS + 4)
`endif

interface axi_aw_router_if #(
  parameter int NUM_SLAVES = 2
);
  // Master AW channel
  logic [`AXI_ID_BITS-1:0]   AWID;
  logic [`AXI_ADDR_BITS-1:0] AWADDR;
  logic [`AXI_LEN_BITS-1:0]  AWLEN;
  logic [`AXI_SIZE_BITS-1:0] AWSIZE;
  logic [1:0]                AWBURST;
  logic                      AWVALID;
  logic                      AWREADY;
  // Broadcast AW payload plus per-slave handshake
  logic [`AXI_IDS_BITS-1:0]  AWID_S;
  logic [`AXI_ADDR_BITS-1:0] AWADDR_S;
  logic [`AXI_LEN_BITS-1:0]  AWLEN_S;
  logic [`AXI_SIZE_BITS-1:0] AWSIZE_S;
  logic [1:0]                AWBURST_S;
  logic [NUM_SLAVES-1:0]     AWVALID_S;
  logic [NUM_SLAVES-1:0]     AWREADY_S;
  // W handshake, master side and per-slave side
  logic                      WVALID;
  logic                      WLAST;
  logic                      WREADY;
  logic [NUM_SLAVES-1:0]     WVALID_S;
  logic [NUM_SLAVES-1:0]     WREADY_S;
  // Default-slave B channel
  logic [`AXI_IDS_BITS-1:0]  BID_D;
  logic [1:0]                BRESP_D;
  logic                      BVALID_D;
  logic                      BREADY_D;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    input  AWREADY_S,
    input  WVALID, WLAST,
    output WREADY,
    output WVALID_S,
    input  WREADY_S,
    output BID_D, BRESP_D, BVALID_D,
    input  BREADY_D
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    output AWREADY_S,
    output WVALID, WLAST,
    input  WREADY,
    input  WVALID_S,
    output WREADY_S,
    input  BID_D, BRESP_D, BVALID_D,
    output BREADY_D
  );
endinterface

// File: rtl/axi_aw_router.sv
// axi_aw_router
//   Routes one AXI master's write-address channel to NUM_SLAVES decoded
//   slaves. Each address is matched against an inclusive [base, limit]
//   window, and the lowest matching index wins. An address that matches
//   no window goes to an internal default slave (DEF). DEF swallows the
//   W data and answers with DECERR on its own B channel.
//   Every accepted AW pushes its destination index into a route FIFO
//   that is OST_DEPTH entries deep. The FIFO head steers the W channel,
//   and a WLAST handshake pops the head.
//   Ports:
//     ACLK, ARESET - clock, synchronous active-high reset
//     bus          - axi_aw_router_if.slave (master AW/W, per-slave AW/W,
//                    DEF B channel)
//     OST_CNT      - route FIFO occupancy
//   Optional feature: when the macro AXI_AW_REG_SLICE_EN is defined, a
//   one-entry register slice drives the slave-facing AW outputs, which
//   adds one cycle of AW latency. When the macro is not defined, the AW
//   path is purely combinational.

module axi_aw_router #(
  parameter int NUM_SLAVES = 2,
  // Index 0 is the rightmost element: slave 0 = 0x0000..0xffff,
  // slave 1 = 0x1_0000..0x1_ffff.
  parameter logic [NUM_SLAVES-1:0][`AXI_ADDR_BITS-1:0] SLV_BASE  = {32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES-1:0][`AXI_ADDR_BITS-1:0] SLV_LIMIT = {32'h0001_ffff, 32'h0000_ffff},
  parameter int OST_DEPTH = 4,
  parameter logic [3:0] MID = 4'h0
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  axi_aw_router_if.slave             bus,
  output logic [$clog2(OST_DEPTH):0] OST_CNT
);

  localparam int SW  = $clog2(NUM_SLAVES + 1);
  localparam int PW  = $clog2(OST_DEPTH);
  localparam int CW  = PW + 1;
  localparam int IDS = `AXI_IDS_BITS;
  localparam logic [SW-1:0] DEF_IDX = SW'(NUM_SLAVES);

  typedef enum logic [1:0] {
    DEF_IDLE,
    DEF_WAIT_W,
    DEF_RESP
  } def_state_e;

  // ---------------------------------------------------------------- decode
  logic [NUM_SLAVES-1:0] hit;
  logic [SW-1:0]         dec_sel;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_dec
    assign hit[gi] = (bus.AWADDR >= SLV_BASE[gi]) && (bus.AWADDR <= SLV_LIMIT[gi]);
  end

  // Scan from the top index down, so the lowest matching index is the
  // last to overwrite dec_sel and therefore wins.
  always_comb begin
    dec_sel = DEF_IDX;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) dec_sel = SW'(i);
    end
  end

  // ------------------------------------------------------------ route FIFO
  logic [SW-1:0] route_mem_q [OST_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty, push, pop;
  logic [SW-1:0] head;

  assign full  = (cnt_q == CW'(OST_DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = route_mem_q[rd_ptr_q];
  assign OST_CNT = cnt_q;

  // --------------------------------------------------------------- AW path
  // ds_* is the slave-facing side of the AW path. It comes either
  // straight from the master or from the register slice.
  logic           ds_valid;
  logic [SW-1:0]  ds_sel;
  logic [IDS-1:0] ds_id;
  logic           ds_ready;
  logic           ds_hs;
  logic           aw_ready;
  logic           aw_hs;
  logic           def_aw_ready;
  logic           def_w_ready;
  logic           def_aw_hs;
  logic [NUM_SLAVES-1:0] aw_valid_s;

  always_comb begin
    ds_ready = def_aw_ready;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (ds_sel == SW'(i)) ds_ready = bus.AWREADY_S[i];
    end
  end

`ifdef AXI_AW_REG_SLICE_EN
  logic                       slice_valid_q, slice_valid_d;
  logic [SW-1:0]              slice_sel_q, slice_sel_d;
  logic [IDS-1:0]             slice_id_q, slice_id_d;
  logic [`AXI_ADDR_BITS-1:0]  slice_addr_q, slice_addr_d;
  logic [`AXI_LEN_BITS-1:0]   slice_len_q, slice_len_d;
  logic [`AXI_SIZE_BITS-1:0]  slice_size_q, slice_size_d;
  logic [1:0]                 slice_burst_q, slice_burst_d;

  assign ds_valid = slice_valid_q;
  assign ds_sel   = slice_sel_q;
  assign ds_id    = slice_id_q;
  assign ds_hs    = ds_valid && ds_ready;
  // The slice can take a new entry when it is empty, or when its current
  // entry leaves in this same cycle.
  assign aw_ready = (!slice_valid_q || ds_hs) && !full;
  assign aw_hs    = bus.AWVALID && aw_ready;

  always_comb begin
    slice_valid_d = slice_valid_q;
    slice_sel_d   = slice_sel_q;
    slice_id_d    = slice_id_q;
    slice_addr_d  = slice_addr_q;
    slice_len_d   = slice_len_q;
    slice_size_d  = slice_size_q;
    slice_burst_d = slice_burst_q;
    if (ds_hs) slice_valid_d = 1'b0;
    if (aw_hs) begin
      slice_valid_d = 1'b1;
      slice_sel_d   = dec_sel;
      slice_id_d    = {MID, bus.AWID};
      slice_addr_d  = bus.AWADDR;
      slice_len_d   = bus.AWLEN;
      slice_size_d  = bus.AWSIZE;
      slice_burst_d = bus.AWBURST;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      slice_valid_q <= 1'b0;
      slice_sel_q   <= '0;
      slice_id_q    <= '0;
      slice_addr_q  <= '0;
      slice_len_q   <= '0;
      slice_size_q  <= '0;
      slice_burst_q <= '0;
    end else begin
      slice_valid_q <= slice_valid_d;
      slice_sel_q   <= slice_sel_d;
      slice_id_q    <= slice_id_d;
      slice_addr_q  <= slice_addr_d;
      slice_len_q   <= slice_len_d;
      slice_size_q  <= slice_size_d;
      slice_burst_q <= slice_burst_d;
    end
  end

  assign bus.AWID_S    = slice_id_q;
  assign bus.AWADDR_S  = slice_addr_q;
  assign bus.AWLEN_S   = slice_len_q;
  assign bus.AWSIZE_S  = slice_size_q;
  assign bus.AWBURST_S = slice_burst_q;
`else
  assign ds_valid = bus.AWVALID && !full;
  assign ds_sel   = dec_sel;
  assign ds_id    = {MID, bus.AWID};
  assign aw_ready = ds_ready && !full;
  assign aw_hs    = bus.AWVALID && aw_ready;
  assign ds_hs    = aw_hs;

  assign bus.AWID_S    = ds_id;
  assign bus.AWADDR_S  = bus.AWADDR;
  assign bus.AWLEN_S   = bus.AWLEN;
  assign bus.AWSIZE_S  = bus.AWSIZE;
  assign bus.AWBURST_S = bus.AWBURST;
`endif

  assign def_aw_hs = ds_hs && (ds_sel == DEF_IDX);
  assign push      = aw_hs;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_aw_valid
    assign aw_valid_s[gi] = ds_valid && (ds_sel == SW'(gi));
  end

  assign bus.AWVALID_S = aw_valid_s;
  assign bus.AWREADY   = aw_ready;

  // ---------------------------------------------------------------- W path
  logic                  head_ready;
  logic                  w_ready;
  logic [NUM_SLAVES-1:0] w_valid_s;

  always_comb begin
    head_ready = def_w_ready;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (head == SW'(i)) head_ready = bus.WREADY_S[i];
    end
  end

  // An empty FIFO blocks W completely. There is no bypass from AW to W,
  // so a burst can start no earlier than the cycle after its AW handshake.
  assign w_ready = !empty && head_ready;
  assign pop     = bus.WVALID && w_ready && bus.WLAST;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_w_valid
    assign w_valid_s[gi] = !empty && bus.WVALID && (head == SW'(gi));
  end

  assign bus.WVALID_S = w_valid_s;
  assign bus.WREADY   = w_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // The FIFO contents need no reset, because the pointers alone decide
  // which entries are live.
  always_ff @(posedge ACLK) begin
    if (push) route_mem_q[wr_ptr_q] <= dec_sel;
  end

  // --------------------------------------------------------- default slave
  def_state_e     def_state_q, def_state_d;
  logic [IDS-1:0] bid_q, bid_d;

  assign def_aw_ready = (def_state_q == DEF_IDLE);
  assign def_w_ready  = (def_state_q == DEF_WAIT_W) && (head == DEF_IDX);

  always_comb begin
    def_state_d = def_state_q;
    bid_d       = bid_q;
    case (def_state_q)
      DEF_IDLE: begin
        if (def_aw_hs) begin
          bid_d       = ds_id;
          def_state_d = DEF_WAIT_W;
        end
      end
      DEF_WAIT_W: begin
        if (pop && (head == DEF_IDX)) def_state_d = DEF_RESP;
      end
      DEF_RESP: begin
        if (bus.BREADY_D) def_state_d = DEF_IDLE;
      end
      default: def_state_d = DEF_IDLE;
    endcase
  end

  assign bus.BVALID_D = (def_state_q == DEF_RESP);
  assign bus.BRESP_D  = (def_state_q == DEF_RESP) ? 2'b11 : 2'b00;
  assign bus.BID_D    = bid_q;

  // ------------------------------------------------------------ state regs
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      def_state_q <= DEF_IDLE;
      bid_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      def_state_q <= def_state_d;
      bid_q       <= bid_d;
    end
  end

endmodule

// File: tb/tb_axi_aw_router.sv
// tb_axi_aw_router
//   Directed checks of reset, decode, W steering, default-slave DECERR,
//   FIFO-full back-pressure and mid-burst reset. These are followed by
//   randomized traffic compared against a queue-based reference model.

module tb_axi_aw_router;
  localparam int         NS    = 2;
  localparam logic [3:0] MID_V = 4'h0;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic [2:0] ost_cnt;

  axi_aw_router_if #(.NUM_SLAVES(NS)) bus ();

  axi_aw_router #(
    .NUM_SLAVES(NS),
    .OST_DEPTH (4),
    .MID       (MID_V)
  ) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus),
    .OST_CNT(ost_cnt)
  );

  always #5 ACLK = ~ACLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: the queue of outstanding routes (NS = default
  // slave) and the default-slave phase (0 idle, 1 taking W, 2 responding).
  int          route_q[$];
  int          def_phase = 0;
  logic [7:0]  m_bid = '0;
  logic [31:0] m_base  [NS] = '{32'h0000_0000, 32'h0001_0000};
  logic [31:0] m_limit [NS] = '{32'h0000_ffff, 32'h0001_ffff};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    logic [31:0] addr;
    logic [1:0]  awrs, wrs;
    logic [1:0]  exp_awvs, exp_wvs;
    logic        exp_awr, exp_wr, full, nonempty, aw_hs, w_pop;
    int          msel, head, r, nphase;

    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = 3'd2;
    bus.AWBURST = 2'b01; bus.AWVALID = 1'b0; bus.AWREADY_S = '0;
    bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.WREADY_S = '0; bus.BREADY_D = 1'b0;
    ARESET = 1'b1;
    repeat (2) tick();

    // Reset state
    bus.WVALID = 1'b1; #1;
    chk("rst_ost",      ost_cnt,       0);
    chk("rst_bvalid",   bus.BVALID_D,  0);
    chk("rst_bresp",    bus.BRESP_D,   0);
    chk("rst_bid",      bus.BID_D,     0);
    chk("rst_wready",   bus.WREADY,    0);
    chk("rst_wvalid_s", bus.WVALID_S,  0);
    chk("rst_awvalid_s", bus.AWVALID_S, 0);
    bus.WVALID = 1'b0; ARESET = 1'b0;
    tick();

    // Slave 0, zero-latency AW and no AW-to-W bypass
    bus.AWADDR = 32'h0000_1000; bus.AWID = 4'h3; bus.AWLEN = 8'd0; bus.AWVALID = 1'b1;
    bus.AWREADY_S = 2'b01; bus.WVALID = 1'b1; bus.WLAST = 1'b1; bus.WREADY_S = 2'b11; #1;
    chk("s0_awvalid_s", bus.AWVALID_S, 2'b01);
    chk("s0_awready",   bus.AWREADY,   1);
    chk("s0_awid_s",    bus.AWID_S,    {MID_V, 4'h3});
    chk("s0_nobypass_wready",  bus.WREADY,   0);
    chk("s0_nobypass_wvalid_s", bus.WVALID_S, 0);
    tick(); bus.AWVALID = 1'b0; #1;
    chk("s0_ost1",      ost_cnt,      1);
    chk("s0_wvalid_s",  bus.WVALID_S, 2'b01);
    chk("s0_wready",    bus.WREADY,   1);
    tick(); bus.WVALID = 1'b0; #1;
    chk("s0_ost0",      ost_cnt,      0);

    // Slave 1, 4-beat burst
    bus.AWADDR = 32'h0001_0004; bus.AWID = 4'h1; bus.AWLEN = 8'd3; bus.AWVALID = 1'b1;
    bus.AWREADY_S = 2'b10; #1;
    chk("s1_awvalid_s", bus.AWVALID_S, 2'b10);
    chk("s1_awready",   bus.AWREADY,   1);
    tick(); bus.AWVALID = 1'b0; bus.AWREADY_S = 2'b00; bus.WREADY_S = 2'b10; bus.WVALID = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bus.WLAST = (b == 3); #1;
      chk("s1_beat_wvalid_s", bus.WVALID_S, 2'b10);
      chk("s1_beat_wready",   bus.WREADY,   1);
      chk("s1_beat_ost",      ost_cnt,      1);
      tick();
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0; #1;
    chk("s1_ost0", ost_cnt, 0);

    // Default slave: DECERR with the prefixed ID
    bus.AWADDR = 32'h0002_0000; bus.AWID = 4'h5; bus.AWLEN = 8'd1; bus.AWVALID = 1'b1;
    bus.AWREADY_S = 2'b11; #1;
    chk("def_awvalid_s", bus.AWVALID_S, 2'b00);
    chk("def_awready",   bus.AWREADY,   1);
    tick(); bus.AWVALID = 1'b0; bus.WVALID = 1'b1; bus.WLAST = 1'b0; bus.WREADY_S = 2'b00; #1;
    chk("def_b1_wready",   bus.WREADY,   1);
    chk("def_b1_wvalid_s", bus.WVALID_S, 2'b00);
    chk("def_b1_bvalid",   bus.BVALID_D, 0);
    tick(); bus.WLAST = 1'b1; #1;
    chk("def_b2_wready",   bus.WREADY,   1);
    tick(); bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.BREADY_D = 1'b0; #1;
    chk("def_bvalid",  bus.BVALID_D, 1);
    chk("def_bresp",   bus.BRESP_D,  2'b11);
    chk("def_bid",     bus.BID_D,    {MID_V, 4'h5});
    chk("def_ost0",    ost_cnt,      0);
    tick(); #0;
    chk("def_bvalid_hold", bus.BVALID_D, 1);
    bus.BREADY_D = 1'b1;
    tick(); bus.BREADY_D = 1'b0; #1;
    chk("def_bvalid_done", bus.BVALID_D, 0);
    chk("def_bresp_done",  bus.BRESP_D,  0);

    // FIFO full: a fifth AW waits for the first WLAST
    bus.AWADDR = 32'h0000_0100; bus.AWLEN = 8'd0; bus.AWVALID = 1'b1; bus.AWREADY_S = 2'b01;
    bus.WVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; chk("fill_awready", bus.AWREADY, 1);
      tick();
    end
    #1;
    chk("full_ost",       ost_cnt,       4);
    chk("full_awready",   bus.AWREADY,   0);
    chk("full_awvalid_s", bus.AWVALID_S, 2'b00);
    tick();
    bus.WVALID = 1'b1; bus.WLAST = 1'b1; bus.WREADY_S = 2'b01; #1;
    chk("full_pop_wready",   bus.WREADY,  1);
    chk("full_pop_awready",  bus.AWREADY, 0);
    tick(); #0;
    chk("after_pop_ost",     ost_cnt,     3);
    chk("after_pop_awready", bus.AWREADY, 1);
    tick(); #0;
    chk("push_pop_ost", ost_cnt, 3);
    bus.AWVALID = 1'b0;
    repeat (3) tick();
    bus.WVALID = 1'b0; #1;
    chk("drain_ost", ost_cnt, 0);

    // Reset during beat 2 of a 4-beat burst to slave 1
    bus.AWADDR = 32'h0001_0000; bus.AWLEN = 8'd3; bus.AWVALID = 1'b1; bus.AWREADY_S = 2'b10;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b1; bus.WLAST = 1'b0; bus.WREADY_S = 2'b10; #1;
    chk("mid_b1_wready", bus.WREADY, 1);
    tick();
    ARESET = 1'b1; #1;
    chk("mid_b2_wvalid_s", bus.WVALID_S, 2'b10);
    tick(); ARESET = 1'b0; #1;
    chk("mid_rst_ost",      ost_cnt,      0);
    chk("mid_rst_wready",   bus.WREADY,   0);
    chk("mid_rst_wvalid_s", bus.WVALID_S, 2'b00);
    chk("mid_rst_bvalid",   bus.BVALID_D, 0);

    // Reset during a default-slave burst returns DEF to idle with no B
    bus.WVALID = 1'b0; bus.AWADDR = 32'h0003_0000; bus.AWID = 4'h9; bus.AWVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b1; bus.WLAST = 1'b0;
    tick();
    ARESET = 1'b1;
    tick(); ARESET = 1'b0; bus.WLAST = 1'b1; #1;
    chk("def_rst_wready", bus.WREADY,   0);
    chk("def_rst_bvalid", bus.BVALID_D, 0);
    chk("def_rst_bid",    bus.BID_D,    0);
    bus.AWVALID = 1'b1; #1;
    chk("def_rst_awready", bus.AWREADY, 1);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    tick();

    // Randomized traffic against the reference model (DUT is idle here)
    route_q.delete();
    def_phase = 0;
    m_bid = '0;
    for (int c = 0; c < 400; c++) begin
      r = int'($urandom_range(0, 3));
      if (r == 0)      addr = $urandom_range(0, 32'h0000_ffff);
      else if (r == 1) addr = 32'h0001_0000 + $urandom_range(0, 32'h0000_ffff);
      else             addr = 32'h0002_0000 + $urandom_range(0, 32'h7fff_0000);
      bus.AWADDR    = addr;
      bus.AWID      = 4'($urandom_range(0, 15));
      bus.AWVALID   = ($urandom_range(0, 1) == 1);
      awrs          = 2'($urandom_range(0, 3));
      wrs           = 2'($urandom_range(0, 3));
      bus.AWREADY_S = awrs;
      bus.WREADY_S  = wrs;
      bus.WVALID    = ($urandom_range(0, 9) < 7);
      bus.WLAST     = ($urandom_range(0, 2) == 0);
      bus.BREADY_D  = ($urandom_range(0, 1) == 1);
      #1;

      msel = NS;
      for (int s = NS - 1; s >= 0; s--) begin
        if (addr >= m_base[s] && addr <= m_limit[s]) msel = s;
      end
      full     = (route_q.size() == 4);
      nonempty = (route_q.size() != 0);
      head     = nonempty ? route_q[0] : 0;
      exp_awvs = '0;
      if (bus.AWVALID && !full && msel < NS) exp_awvs[msel] = 1'b1;
      exp_awr  = !full && ((msel == NS) ? (def_phase == 0) : awrs[msel]);
      exp_wr   = nonempty && ((head == NS) ? (def_phase == 1) : wrs[head]);
      exp_wvs  = '0;
      if (nonempty && bus.WVALID && head < NS) exp_wvs[head] = 1'b1;

      chk("rnd_awvalid_s", bus.AWVALID_S, exp_awvs);
      chk("rnd_awready",   bus.AWREADY,   exp_awr);
      chk("rnd_awid_s",    bus.AWID_S,    {MID_V, bus.AWID});
      chk("rnd_wvalid_s",  bus.WVALID_S,  exp_wvs);
      chk("rnd_wready",    bus.WREADY,    exp_wr);
      chk("rnd_bvalid",    bus.BVALID_D,  def_phase == 2);
      chk("rnd_bresp",     bus.BRESP_D,   (def_phase == 2) ? 2'b11 : 2'b00);
      chk("rnd_bid",       bus.BID_D,     m_bid);
      chk("rnd_ost",       ost_cnt,       route_q.size());

      aw_hs  = bus.AWVALID && exp_awr;
      w_pop  = bus.WVALID && exp_wr && bus.WLAST;
      nphase = def_phase;
      if (def_phase == 0 && aw_hs && msel == NS) begin
        nphase = 1;
        m_bid  = {MID_V, bus.AWID};
      end
      if (def_phase == 1 && w_pop && head == NS) nphase = 2;
      if (def_phase == 2 && bus.BREADY_D) nphase = 0;
      def_phase = nphase;
      if (w_pop) void'(route_q.pop_front());
      if (aw_hs) route_q.push_back(msel);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
